rpn_stack: RTL and testbench

- LIFO operand stack for the RPN calculator datapath; the ALU pushes ASCII digit/result bytes and pops operands.
- Strobe/ack interface on both sides. Top-of-stack is always visible on POP_DAT.
- A simultaneous push and pop replaces the top entry, which the ALU uses for "pop operand, push result".

---
 rtl/rpn_stack.sv | 91 +++++++++
 tb/tb_rpn_stack.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack.sv
// LIFO operand stack for the RPN calculator datapath.
// Edge-detected push/pop strobes; a simultaneous push and pop overwrites the top entry.
module rpn_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH_STB,
    input  logic [WIDTH-1:0] PUSH_DAT,
    output logic             PUSH_ACK,
    output logic             POP_STB,
    output logic [WIDTH-1:0] POP_DAT,
    input  logic             POP_ACK
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] sp_reg, sp_next;
    logic             push_q_reg;
    logic             pop_q_reg;
    logic             ack_reg, ack_next;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_addr;
    logic             push_ev, pop_ev;
    logic             empty, full;

    assign push_ev  = PUSH_STB & ~push_q_reg;
    assign pop_ev   = POP_ACK & ~pop_q_reg;
    assign empty    = (sp_reg == '0);
    assign full     = (sp_reg == PTR_W'(DEPTH));
    // Low bits wrap correctly even at sp == DEPTH, so no wide subtract is needed.
    assign top_addr = sp_reg[AW-1:0] - AW'(1);

    always_comb begin
        sp_next  = sp_reg;
        ack_next = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = sp_reg[AW-1:0];
        if (push_ev && pop_ev) begin
            wr_en    = 1'b1;
            ack_next = 1'b1;
            if (empty) begin
                wr_addr = '0;
                sp_next = PTR_W'(1);
            end else begin
                wr_addr = top_addr;
            end
        end else if (push_ev) begin
            if (!full) begin
                wr_en    = 1'b1;
                ack_next = 1'b1;
                sp_next  = sp_reg + PTR_W'(1);
            end
        end else if (pop_ev) begin
            if (!empty) begin
                sp_next = sp_reg - PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_reg     <= '0;
            push_q_reg <= 1'b0;
            pop_q_reg  <= 1'b0;
            ack_reg    <= 1'b0;
        end else begin
            sp_reg     <= sp_next;
            push_q_reg <= PUSH_STB;
            pop_q_reg  <= POP_ACK;
            ack_reg    <= ack_next;
        end
    end

    // Storage has no reset; reset still blocks a write that coincides with it.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem[wr_addr] <= PUSH_DAT;
        end
    end

    assign PUSH_ACK = ack_reg;
    assign POP_STB  = ~empty;
    assign POP_DAT  = empty ? '0 : mem[top_addr];

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack: a queue-based stack model feeds a scoreboard of
// expected outputs that is drained and compared one cycle after each step.
module tb_rpn_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PTR_W = 5;

    logic             CLK;
    logic             RST;
    logic             PUSH_STB;
    logic [WIDTH-1:0] PUSH_DAT;
    logic             PUSH_ACK;
    logic             POP_STB;
    logic [WIDTH-1:0] POP_DAT;
    logic             POP_ACK;

    rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PUSH_STB (PUSH_STB),
        .PUSH_DAT (PUSH_DAT),
        .PUSH_ACK (PUSH_ACK),
        .POP_STB  (POP_STB),
        .POP_DAT  (POP_DAT),
        .POP_ACK  (POP_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string            tag;
        logic             stb;
        logic [WIDTH-1:0] dat;
        logic             ack;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] stk[$];
    logic             m_push_q;
    logic             m_pop_q;
    logic             m_ack;
    int               checks;
    int               errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        return (stk.size() != 0) ? stk[stk.size()-1] : '0;
    endfunction

    // One clock: drive inputs, advance the model, queue its prediction, compare after the edge.
    task automatic step(input string tag, input logic rst, input logic ps,
                        input logic [WIDTH-1:0] pd, input logic pa);
        exp_t e;
        exp_t got;
        logic pe, oe;
        RST      = rst;
        PUSH_STB = ps;
        PUSH_DAT = pd;
        POP_ACK  = pa;
        #1;
        if (!rst && pa) chk({tag, "_pre_pop_dat"}, 32'(POP_DAT), 32'(model_top()));
        if (rst) begin
            stk.delete();
            m_push_q = 1'b0;
            m_pop_q  = 1'b0;
            m_ack    = 1'b0;
        end else begin
            pe    = ps & ~m_push_q;
            oe    = pa & ~m_pop_q;
            m_ack = 1'b0;
            if (pe && oe) begin
                if (stk.size() != 0) stk[stk.size()-1] = pd;
                else stk.push_back(pd);
                m_ack = 1'b1;
            end else if (pe) begin
                if (stk.size() < DEPTH) begin
                    stk.push_back(pd);
                    m_ack = 1'b1;
                end
            end else if (oe) begin
                if (stk.size() != 0) void'(stk.pop_back());
            end
            m_push_q = ps;
            m_pop_q  = pa;
        end
        e.tag = tag;
        e.stb = (stk.size() != 0);
        e.dat = model_top();
        e.ack = m_ack;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        chk({got.tag, "_stb"}, 32'(POP_STB), 32'(got.stb));
        chk({got.tag, "_dat"}, 32'(POP_DAT), 32'(got.dat));
        chk({got.tag, "_ack"}, 32'(PUSH_ACK), 32'(got.ack));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_push_q = 1'b0;
        m_pop_q  = 1'b0;
        m_ack    = 1'b0;
        RST      = 1'b1;
        PUSH_STB = 1'b0;
        PUSH_DAT = '0;
        POP_ACK  = 1'b0;

        // Reset and idle
        step("rst0", 1, 0, 8'h00, 0);
        step("rst1", 1, 0, 8'h00, 0);
        step("idle0", 0, 0, 8'h00, 0);
        step("idle1", 0, 0, 8'h00, 0);
        chk("idle_stb_const", 32'(POP_STB), 32'd0);
        chk("idle_dat_const", 32'(POP_DAT), 32'h00);

        // Held strobe yields a single push
        for (int i = 0; i < 4; i++) step($sformatf("hold%0d", i), 0, 1, 8'h33, 0);
        step("hold_drop", 0, 0, 8'h00, 0);
        chk("hold_one_entry", 32'(POP_DAT), 32'h33);
        step("hold_pop", 0, 0, 8'h00, 1);
        step("hold_pop_rel", 0, 0, 8'h00, 0);

        // Push two, pop three (last one on empty)
        step("p32", 0, 1, 8'h32, 0);
        step("p32_rel", 0, 0, 8'h00, 0);
        step("p33", 0, 1, 8'h33, 0);
        step("p33_rel", 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("pop%0d", i), 0, 0, 8'h00, 1);
            step($sformatf("pop%0d_rel", i), 0, 0, 8'h00, 0);
        end
        chk("underflow_stb_const", 32'(POP_STB), 32'd0);

        // Replace flow: [32,33] -> push+pop 35 -> [32,35]
        step("r32", 0, 1, 8'h32, 0);
        step("r32_rel", 0, 0, 8'h00, 0);
        step("r33", 0, 1, 8'h33, 0);
        step("r33_rel", 0, 0, 8'h00, 0);
        step("repl35", 0, 1, 8'h35, 1);
        step("repl_rel", 0, 0, 8'h00, 0);
        chk("repl_top_const", 32'(POP_DAT), 32'h35);
        step("repl_pop", 0, 0, 8'h00, 1);
        step("repl_pop_rel", 0, 0, 8'h00, 0);
        chk("repl_under_const", 32'(POP_DAT), 32'h32);
        step("repl_pop2", 0, 0, 8'h00, 1);
        step("repl_pop2_rel", 0, 0, 8'h00, 0);

        // Fill to DEPTH, reject overflow, replace while full, drain in reverse
        for (int i = 0; i < DEPTH; i++) begin
            step($sformatf("fill%0d", i), 0, 1, WIDTH'(8'h30 + i), 0);
            step($sformatf("fill%0d_rel", i), 0, 0, 8'h00, 0);
        end
        step("ovf41", 0, 1, 8'h41, 0);
        chk("ovf_ack_const", 32'(PUSH_ACK), 32'd0);
        chk("ovf_top_const", 32'(POP_DAT), 32'h3F);
        step("ovf_rel", 0, 0, 8'h00, 0);
        step("full_repl", 0, 1, 8'h3F, 1);
        step("full_repl_rel", 0, 0, 8'h00, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step($sformatf("drain%0d", i), 0, 0, 8'h00, 1);
            step($sformatf("drain%0d_rel", i), 0, 0, 8'h00, 0);
        end

        // Simultaneous push+pop on empty acts as a plain push
        step("empty_both37", 0, 1, 8'h37, 1);
        chk("empty_both_top_const", 32'(POP_DAT), 32'h37);
        step("empty_both_rel", 0, 0, 8'h00, 0);

        // Mid-sequence reset with sp=3, push strobe held through reset release
        step("m1", 0, 1, 8'h38, 0);
        step("m1_rel", 0, 0, 8'h00, 0);
        step("m2", 0, 1, 8'h39, 0);
        step("m2_hold", 0, 1, 8'h39, 0);
        step("mid_rst", 1, 1, 8'h3A, 0);
        chk("mid_rst_stb_const", 32'(POP_STB), 32'd0);
        step("post_rst_edge", 0, 1, 8'h3A, 0);
        step("post_rst_hold", 0, 1, 8'h3A, 0);
        step("post_rst_rel", 0, 0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
